// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit owning the architectural HI/LO
// registers. MULT/MULTU/DIV/DIVU take n+1 cycles (n shift steps plus a sign
// fix-up/commit cycle). MTHI/MTLO write in a single cycle. Divide by zero
// completes on the next edge without touching HI/LO.
module hilo_muldiv #(
  parameter int n = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(n - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [n-1:0]   hi_q, hi_d;
  logic [n-1:0]   lo_q, lo_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  // Operation kind and result signs remembered for the fix-up cycle.
  logic           isDiv_q, isDiv_d;
  logic           negRes_q, negRes_d;
  logic           negRem_q, negRem_d;
  // Shadow datapath: acc is the running product high half / partial remainder,
  // shr holds the multiplier bits (shifting out) or the dividend bits (shifting
  // out) while quotient/product low bits shift in; opnd is the fixed operand.
  logic [n-1:0]   acc_q, acc_d;
  logic [n-1:0]   shr_q, shr_d;
  logic [n-1:0]   opnd_q, opnd_d;

  logic           opMul;
  logic           opDiv;
  logic           aNeg;
  logic           bNeg;
  logic [n-1:0]   absA;
  logic [n-1:0]   absB;
  logic [n:0]     mulSum;
  logic [n:0]     remShift;
  logic           canSub;
  logic [n-1:0]   remSub;
  logic [2*n-1:0] product;
  logic [2*n-1:0] negProduct;

  // Decode the issued op and take operand magnitudes for the signed variants.
  always_comb begin
    opMul = (op == OP_MULT) || (op == OP_MULTU);
    opDiv = (op == OP_DIV) || (op == OP_DIVU);
    aNeg  = ((op == OP_MULT) || (op == OP_DIV)) && a[n-1];
    bNeg  = ((op == OP_MULT) || (op == OP_DIV)) && b[n-1];
    absA  = aNeg ? -a : a;
    absB  = bNeg ? -b : b;
  end

  // One iteration of shift-add multiply and restoring divide, plus the
  // full-width product used at commit. The remainder after a successful
  // subtract is always below the divisor, so an n-bit difference is exact.
  always_comb begin
    mulSum     = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opnd_q} : {(n+1){1'b0}});
    remShift   = {acc_q, shr_q[n-1]};
    canSub     = (remShift >= {1'b0, opnd_q});
    remSub     = {acc_q[n-2:0], shr_q[n-1]} - opnd_q;
    product    = {acc_q, shr_q};
    negProduct = -product;
  end

  // Next-state logic: issue in IDLE, iterate in RUN, sign-correct and commit in FIX.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    isDiv_d  = isDiv_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    acc_d    = acc_q;
    shr_d    = shr_q;
    opnd_d   = opnd_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (opMul || (opDiv && (b != '0))) begin
            state_d  = RUN;
            count_d  = '0;
            isDiv_d  = opDiv;
            negRes_d = aNeg ^ bNeg;
            negRem_d = aNeg;
            acc_d    = '0;
            shr_d    = opDiv ? absA : absB;
            opnd_d   = opDiv ? absB : absA;
          end else if (opDiv) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end

      RUN: begin
        if (isDiv_q) begin
          if (canSub) begin
            acc_d = remSub;
            shr_d = {shr_q[n-2:0], 1'b1};
          end else begin
            acc_d = remShift[n-1:0];
            shr_d = {shr_q[n-2:0], 1'b0};
          end
        end else begin
          acc_d = mulSum[n:1];
          shr_d = {mulSum[0], shr_q[n-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          state_d = FIX;
          count_d = '0;
        end
      end

      FIX: begin
        if (isDiv_q) begin
          lo_d = negRes_q ? -shr_q : shr_q;
          hi_d = negRem_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = negRes_q ? negProduct : product;
        end
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      isDiv_q  <= 1'b0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      acc_q    <= '0;
      shr_q    <= '0;
      opnd_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      isDiv_q  <= isDiv_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      acc_q    <= acc_d;
      shr_q    <= shr_d;
      opnd_q   <= opnd_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases plus random ops,
// expected results from plain 64-bit arithmetic queued at issue time and
// compared by an independent monitor whenever done pulses.
module tb_hilo_muldiv;

  localparam int N = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b1;
  logic          start   = 1'b0;
  logic [2:0]    op      = OP_NOP;
  logic [N-1:0]  a       = '0;
  logic [N-1:0]  b       = '0;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          doneCyc;
    int          busyCyc;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  int          busyCount = 0;
  logic [31:0] modelHi   = '0;
  logic [31:0] modelLo   = '0;

  hilo_muldiv #(.n(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // Free-running clock and cycle counter used for latency checks.
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference results from the architectural definition using 64-bit math.
  function automatic exp_t refModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx;
    longint      sy;
    longint      p;
    longint      q;
    longint      r;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    e.hi      = modelHi;
    e.lo      = modelLo;
    e.dbz     = 1'b0;
    e.busyCyc = N + 1;
    e.doneCyc = 0;
    case (o)
      OP_MULT: begin
        p = sx * sy;
        {e.hi, e.lo} = p;
      end
      OP_MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        {e.hi, e.lo} = up;
      end
      OP_DIV, OP_DIVU: begin
        if (y == 32'd0) begin
          e.dbz     = 1'b1;
          e.busyCyc = 0;
        end else if (o == OP_DIV) begin
          q = sx / sy;
          r = sx % sy;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (busy !== 1'b0) begin
      if (guard == 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL idleTimeout: got busy=%b, expected 0 within 200 cycles", busy);
        return;
      end
      @(posedge clock);
      #2;
      guard++;
    end
  endtask

  // Issue one op for a single cycle once the unit is idle and record what
  // the architecture should show afterwards.
  task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
    exp_t e;
    waitIdle();
    op    = opIn;
    a     = aIn;
    b     = bIn;
    start = 1'b1;
    if (opIn <= OP_DIVU) begin
      e = refModel(opIn, aIn, bIn);
      e.doneCyc = (e.busyCyc == 0) ? cyc + 1 : cyc + N + 2;
      expQ.push_back(e);
      modelHi = e.hi;
      modelLo = e.lo;
    end else if (opIn == OP_MTHI) begin
      modelHi = aIn;
    end else if (opIn == OP_MTLO) begin
      modelLo = aIn;
    end
    @(posedge clock);
    #2;
    start = 1'b0;
    op    = OP_NOP;
    a     = $urandom;
    b     = $urandom;
    if (opIn >= OP_MTHI) begin
      checkOutput("singleCycleHi", hi, modelHi);
      checkOutput("singleCycleLo", lo, modelLo);
      checkOutput("singleCycleBusy", {31'd0, busy}, 32'd0);
    end
  endtask

  // Monitor: pops the scoreboard whenever the unit signals completion.
  always @(negedge clock) begin
    if (!reset_n) begin
      busyCount = 0;
    end else begin
      if (busy === 1'b1) busyCount++;
      if (done === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone: got done=1, expected no pending op (cycle %0d)", cyc);
        end else begin
          monE = expQ.pop_front();
          checkOutput("resultHi", hi, monE.hi);
          checkOutput("resultLo", lo, monE.lo);
          checkOutput("divByZero", {31'd0, div_by_zero}, {31'd0, monE.dbz});
          checkOutput("doneCycle", 32'(cyc), 32'(monE.doneCyc));
          checkOutput("busyCycles", 32'(busyCount), 32'(monE.busyCyc));
          checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
        end
        busyCount = 0;
      end
    end
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    $display("[TB] starting hilo_muldiv bench");
    #2 reset_n = 1'b0;
    #1;
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetDbz", {31'd0, div_by_zero}, 32'd0);
    checkOutput("resetHi", hi, 32'd0);
    checkOutput("resetLo", lo, 32'd0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #2;

    // Directed corner cases.
    applyStimulus(OP_MULT,  32'hFFFF_FFFF, 32'd2);
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    applyStimulus(OP_DIVU,  32'd7,         32'd2);
    applyStimulus(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(OP_MTHI,  32'h0000_00AA, 32'd0);
    applyStimulus(OP_MTLO,  32'h0000_00BB, 32'd0);
    applyStimulus(OP_DIV,   32'd5,         32'd0);
    applyStimulus(OP_DIVU,  32'd9,         32'd0);
    applyStimulus(OP_MTHI,  32'h0000_1234, 32'd0);
    applyStimulus(OP_NOP,   32'h5555_5555, 32'd1);
    applyStimulus(3'b111,   32'h6666_6666, 32'd1);

    // Start while busy must be ignored, including MTLO.
    applyStimulus(OP_MULT, 32'h0001_2345, 32'hFFFF_0003);
    repeat (4) @(posedge clock);
    #2;
    start = 1'b1;
    op    = OP_MTLO;
    a     = 32'hDEAD_BEEF;
    @(posedge clock);
    #2;
    start = 1'b0;
    op    = OP_NOP;
    waitIdle();
    checkOutput("ignoredMtloLo", lo, modelLo);

    // Back-to-back multiplies: the second issues in the done cycle of the first.
    applyStimulus(OP_MULTU, 32'd5, 32'd6);
    applyStimulus(OP_MULTU, 32'd7, 32'd8);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 100);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'd1;
        3:       rb = $urandom_range(1, 50);
        default: rb = $urandom;
      endcase
      applyStimulus(rop, ra, rb);
    end

    // Reset in the middle of a divide aborts it and clears everything.
    applyStimulus(OP_DIVU, 32'hCAFE_F00D, 32'd3);
    repeat (9) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortDone", {31'd0, done}, 32'd0);
    checkOutput("abortHi", hi, 32'd0);
    checkOutput("abortLo", lo, 32'd0);
    expQ.delete();
    modelHi = '0;
    modelLo = '0;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #2;
    applyStimulus(OP_MULTU, 32'd3, 32'd4);

    // Drain and confirm every issued op completed.
    waitIdle();
    repeat (3) @(posedge clock);
    #2;
    checkOutput("pendingOps", 32'(expQ.size()), 32'd0);
    checkOutput("finalHi", hi, modelHi);
    checkOutput("finalLo", lo, modelLo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
